// File: rtl/pipelined_lookahead_adder_if.sv
// Operand/result handshake bundle for pipelined_lookahead_adder.
// ADDSUB_MODE_EN adds sub (with a/b) and ovf (with sum).
interface pipelined_lookahead_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDSUB_MODE_EN
  logic             sub;
  logic             ovf;

  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipelined_lookahead_adder.sv
// Pipelined carry-lookahead adder, STAGES segments of BLK-bit CLA blocks; ADDSUB_MODE_EN adds sub/ovf.
// Latency STAGES cycles, throughput one result per cycle.
// Backpressure: stalled stages hold, empty stages still fill; in_ready drops only when every stage is full.
module pipelined_lookahead_adder #(
  parameter int WIDTH  = 64,
  parameter int BLK    = 4,
  parameter int STAGES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pipelined_lookahead_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  b_eff;

`ifdef ADDSUB_MODE_EN
  assign b_eff = bus.b ^ {WIDTH{bus.sub}};
`else
  assign b_eff = bus.b;
`endif

  // A stage may move unless it and every later stage are full while the sink stalls.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full & vld[k];
      adv[k] = bus.out_ready | ~full;
    end
  end

  assign bus.in_ready = adv[0];

  // Chain of BLK-bit blocks; inside a block every carry is a flat sum of products of g/p and block carry-in.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] s;
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           t;
    s    = '0;
    c    = '0;
    t    = 1'b0;
    c[0] = ci;
    for (int n = 0; n < SEG / BLK; n++) begin
      g = x[n*BLK +: BLK] & y[n*BLK +: BLK];
      p = x[n*BLK +: BLK] ^ y[n*BLK +: BLK];
      for (int i = 1; i <= BLK; i++) begin
        t = c[0];
        for (int j = 0; j < i; j++) t = t & p[j];
        c[i] = t;
        for (int j = 0; j < i; j++) begin
          t = g[j];
          for (int m = j + 1; m < i; m++) t = t & p[m];
          c[i] = c[i] | t;
        end
      end
      s[n*BLK +: BLK] = p ^ c[BLK-1:0];
      c[0] = c[BLK];
    end
    return {c[0], s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW = WIDTH - (k + 1) * SEG;

    logic [RW+SEG-1:0]      src_a;
    logic [RW+SEG-1:0]      src_b;
    logic                   src_c;
    logic                   src_v;
    logic [SEG:0]           res;
    logic [(k+1)*SEG-1:0]   sum_nxt;
    logic [(k+1)*SEG-1:0]   sum_q;
    logic                   vld_q;
    logic                   cry_q;

    if (k == 0) begin : g_first
      assign src_a   = bus.a;
      assign src_b   = b_eff;
      assign src_c   = bus.cin;
      assign src_v   = bus.in_valid;
      assign sum_nxt = res[SEG-1:0];
    end else begin : g_next
      assign src_a   = g_stg[k-1].g_fwd.opa_q;
      assign src_b   = g_stg[k-1].g_fwd.opb_q;
      assign src_c   = g_stg[k-1].cry_q;
      assign src_v   = g_stg[k-1].vld_q;
      assign sum_nxt = {res[SEG-1:0], g_stg[k-1].sum_q};
    end

    assign res    = seg_add(src_a[SEG-1:0], src_b[SEG-1:0], src_c);
    assign vld[k] = vld_q;

    // Data only loads with a valid token so the output keeps the last real result across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        sum_q <= '0;
      end else if (adv[k]) begin
        vld_q <= src_v;
        if (src_v) begin
          cry_q <= res[SEG];
          sum_q <= sum_nxt;
        end
      end
    end

    if (RW > 0) begin : g_fwd
      logic [RW-1:0] opa_q;
      logic [RW-1:0] opb_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (adv[k] && src_v) begin
          opa_q <= src_a[RW+SEG-1:SEG];
          opb_q <= src_b[RW+SEG-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      assign bus.out_valid = vld_q;
      assign bus.sum       = sum_q;
      assign bus.cout      = cry_q;
`ifdef ADDSUB_MODE_EN
      logic ovf_q;
      // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv[k] && src_v) begin
          ovf_q <= res[SEG] ^ res[SEG-1] ^ src_a[SEG-1] ^ src_b[SEG-1];
        end
      end
      assign bus.ovf = ovf_q;
`endif
    end
  end
endmodule

// File: tb/tb_pipelined_lookahead_adder.sv
// Randomized bench for pipelined_lookahead_adder against an arithmetic reference queue.
module tb_pipelined_lookahead_adder;
  localparam int WIDTH  = 64;
  localparam int BLK    = 4;
  localparam int STAGES = 4;

  typedef logic [WIDTH:0] word_t;
  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_lookahead_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_lookahead_adder #(
    .WIDTH (WIDTH),
    .BLK   (BLK),
    .STAGES(STAGES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  res_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   lat;
`ifdef ADDSUB_MODE_EN
  logic sub_drv = 1'b0;
`endif

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One clock: drive at negedge, check/score 1ns later, transfer at the following posedge.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic ordy);
    res_t             e;
    logic [WIDTH-1:0] be;
    word_t            t;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = ci;
    bus.out_ready = ordy;
`ifdef ADDSUB_MODE_EN
    bus.sub = sub_drv;
`endif
    #1;
    chk("in_ready", word_t'(bus.in_ready), word_t'(ordy || exp_q.size() < STAGES));
    if (bus.out_valid && exp_q.size() == 0) begin
      chk("spurious_out", word_t'(bus.out_valid), '0);
    end else if (bus.out_valid && !ordy) begin
      chk("hold_sum", word_t'(bus.sum), word_t'(exp_q[0].s));
      chk("hold_cout", word_t'(bus.cout), word_t'(exp_q[0].c));
    end else if (bus.out_valid) begin
      e = exp_q.pop_front();
      chk("sum", word_t'(bus.sum), word_t'(e.s));
      chk("cout", word_t'(bus.cout), word_t'(e.c));
`ifdef ADDSUB_MODE_EN
      chk("ovf", word_t'(bus.ovf), word_t'(e.o));
`endif
    end
    if (iv && bus.in_ready) begin
      be = b;
`ifdef ADDSUB_MODE_EN
      if (sub_drv) be = ~b;
`endif
      t   = {1'b0, a} + {1'b0, be} + word_t'(ci);
      e.s = t[WIDTH-1:0];
      e.c = t[WIDTH];
      e.o = (a[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1);
      if (bus.out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drain_left", word_t'(exp_q.size()), '0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ADDSUB_MODE_EN
    bus.sub = 1'b0;
`endif
    #2;
    chk("rst_out_valid", word_t'(bus.out_valid), '0);
    chk("rst_sum", word_t'(bus.sum), '0);
    chk("rst_cout", word_t'(bus.cout), '0);
    chk("rst_in_ready", word_t'(bus.in_ready), word_t'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Carry from segment 1 into segment 2.
    cycle(1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    wait_out(lat);
    chk("op1_lat", word_t'(lat), word_t'(STAGES));
    chk("op1_sum", word_t'(bus.sum), word_t'(64'h0000_0001_0000_0000));
    chk("op1_cout", word_t'(bus.cout), '0);

    // Carry through every segment.
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1);
    wait_out(lat);
    chk("chain_lat", word_t'(lat), word_t'(STAGES));
    chk("chain_sum", word_t'(bus.sum), '0);
    chk("chain_cout", word_t'(bus.cout), word_t'(1));

    for (int i = 0; i < 100; i++) begin
`ifdef ADDSUB_MODE_EN
      sub_drv = 1'($urandom_range(0, 1));
`endif
      cycle(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    for (int i = 0; i < 20; i++) cycle(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 6; i++)  cycle(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 3) != 0), rnd(), rnd(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
    drain();

    for (int i = 0; i < 3; i++) cycle(1'b1, rnd(), rnd(), 1'b0, 1'b1);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", word_t'(bus.out_valid), '0);
    chk("midrst_sum", word_t'(bus.sum), '0);
    chk("midrst_cout", word_t'(bus.cout), '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b1);
    wait_out(lat);
    chk("post_rst_lat", word_t'(lat), word_t'(STAGES));
    drain();

`ifdef ADDSUB_MODE_EN
    sub_drv = 1'b1;
    cycle(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    wait_out(lat);
    chk("sub_sum", word_t'(bus.sum), word_t'(64'h8000_0000_0000_0000));
    chk("sub_ovf", word_t'(bus.ovf), word_t'(1));
    sub_drv = 1'b0;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
